// File: rtl/pdm_decim_out.sv
// Purpose: decimates a CIC integrator stream by DECIM, removes DC and buffers samples for a consumer.
// Latency: an output is pushed two cycles after the capture strobe (capture -> stage 1 -> stage 2 push).
// Backpressure: valid/ready pop from a DEPTH-entry FIFO; a push into a full FIFO without a pop is dropped and flagged.

// Generic synchronous FIFO used for output buffering (DEPTH must be a power of two, at least 2).
// Latency: a write is visible at the head on the cycle after it is accepted.
// Backpressure: a write into a full FIFO is accepted only when a read happens in the same cycle, otherwise it is dropped.
module pdm_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          wr_ok;

    assign full   = (count == FULL_LVL);
    assign rd_vld = (count != '0);
    // A read on the same cycle frees the slot, so a full FIFO can still take the write.
    assign pop    = rd_vld && rd_rdy;
    assign wr_ok  = wr_vld && (!full || pop);
    assign drop   = wr_vld && full && !pop;
    // Head is shown only while occupied so the output reads zero when empty.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module pdm_decim_out #(
    parameter int DECIM    = 32,
    parameter int DC_SHIFT = 8,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [11:0]       cic_in,
    input  logic                     dc_bypass,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [15:0]       out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int CW   = $clog2(DECIM);
    localparam int ACCW = 16 + DC_SHIFT;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

    logic [CW-1:0]            dec_cnt;
    logic                     cap;
    logic signed [15:0]       s1_x;
    logic                     s1_vld;
    logic signed [ACCW-1:0]   dc_acc;
    logic signed [15:0]       dc;
    logic [16:0]              diff;
    logic signed [15:0]       y_sat;
    logic signed [15:0]       s2_y;
    logic [15:0]              fifo_dat;
    logic                     fifo_drop;

    // One capture per DECIM strobes, on the strobe that completes the count.
    assign cap = en && (dec_cnt == CNT_LAST);

    // Decimation counter; DECIM is a power of two so the wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (en) begin
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

    // Stage 1: capture the CIC word scaled into the 16-bit output range (x16).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_x   <= '0;
        end else begin
            s1_vld <= cap;
            if (cap) begin
                s1_x <= {cic_in, 4'b0000};
            end
        end
    end

    // Stage 2: DC estimate is the leaky accumulator scaled down by 2^DC_SHIFT.
    assign dc   = dc_acc[ACCW-1:DC_SHIFT];
    assign diff = {s1_x[15], s1_x} - {dc[15], dc};

    // Saturate the 17-bit difference back into 16 bits.
    always_comb begin
        y_sat = diff[15:0];
        if (diff[16] != diff[15]) begin
            y_sat = diff[16] ? 16'sh8000 : 16'sh7fff;
        end
    end

    assign s2_y = dc_bypass ? s1_x : y_sat;

    // DC tracker integrates the residual; frozen while bypassed so it resumes where it left off.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_acc <= '0;
        end else if (s1_vld && !dc_bypass) begin
            dc_acc <= dc_acc + {{(ACCW-17){diff[16]}}, diff};
        end
    end

    pdm_fifo #(
        .W     (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (s1_vld),
        .wr_dat (s2_y),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (fifo_dat),
        .count  (level),
        .drop   (fifo_drop)
    );

    assign out_data = fifo_dat;

    // Sticky drop flag; a drop in the same cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pdm_decim_out.sv
module tb_pdm_decim_out;
    localparam int DECIM = 32;
    localparam int K     = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [11:0] cic_in;
    logic               dc_bypass;
    logic               clr_ovf;
    logic               out_ready;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic [2:0]         level;
    logic               overflow;

    int     vectors = 0;
    int     miscompares = 0;
    int     exp_q[$];
    int     got_q[$];
    int     m_cnt = 0;
    longint m_acc = 0;
    int     e_val;

    pdm_decim_out #(.DECIM(DECIM), .DC_SHIFT(K), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cic_in    (cic_in),
        .dc_bypass (dc_bypass),
        .clr_ovf   (clr_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted output is compared with the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            got_q.push_back(int'(out_data));
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got %0d, required no output", int'(out_data));
            end else begin
                e_val = exp_q.pop_front();
                if (int'(out_data) !== e_val) begin
                    miscompares++;
                    $display("FAIL sb_data: got %0d, required %0d", int'(out_data), e_val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_acc = 0;
        exp_q.delete();
    endtask

    // Drives one cycle; the reference model predicts the sample for each capture strobe.
    task automatic drive_cycle(input logic e);
        int x, dc, diff, y;
        en = e;
        if (e) begin
            if (m_cnt == DECIM - 1) begin
                x = int'(cic_in) * 16;
                if (dc_bypass) begin
                    y = x;
                end else begin
                    dc = int'(m_acc >>> K);
                    diff = x - dc;
                    m_acc = m_acc + longint'(diff);
                    y = (diff > 32767) ? 32767 : ((diff < -32768) ? -32768 : diff);
                end
                exp_q.push_back(y);
            end
            m_cnt = (m_cnt + 1) % DECIM;
        end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        clr_ovf = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            drive_cycle(1'b0);
            n++;
        end
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0; cic_in = '0; dc_bypass = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        vectors++;
        if (out_data !== 16'sd0) begin miscompares++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
        vectors++;
        if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d, required 0", level); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_latency_bypass();
        do_reset();
        dc_bypass = 1'b1; cic_in = 12'sd100; out_ready = 1'b1;
        for (int i = 0; i < DECIM - 1; i++) begin
            drive_cycle(1'b1);
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL early_valid strobe %0d: got %b, required 0", i + 1, out_valid); end
        end
        drive_cycle(1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL valid_after_1: got %b, required 0", out_valid); end
        drive_cycle(1'b1);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL valid_after_2: got %b, required 1", out_valid); end
        vectors++;
        if (out_data !== 16'sd1600) begin miscompares++; $display("FAIL first_bypass: got %0d, required 1600", out_data); end
        for (int i = 0; i < 4 * DECIM; i++) drive_cycle(1'b1);
        drain(20);
    endtask

    task automatic test_dc_removal();
        int bad = 0;
        do_reset();
        dc_bypass = 1'b0; cic_in = 12'sd100; out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 2000 * DECIM; i++) drive_cycle(1'b1);
        drain(20);
        vectors++;
        if (got_q.size() != 2000) begin miscompares++; $display("FAIL dc_count: got %0d, required 2000", got_q.size()); end
        if (got_q.size() > 0) begin
            for (int i = 1; i < got_q.size(); i++) if (got_q[i] > got_q[i-1]) bad++;
            vectors++;
            if (got_q[0] !== 1600) begin miscompares++; $display("FAIL dc_first: got %0d, required 1600", got_q[0]); end
            vectors++;
            if (bad !== 0) begin miscompares++; $display("FAIL dc_monotonic: got %0d rises, required 0", bad); end
            vectors++;
            if (got_q[got_q.size()-1] >= 16) begin miscompares++; $display("FAIL dc_settle: got %0d, required below 16", got_q[got_q.size()-1]); end
        end
    endtask

    task automatic test_overflow_and_full();
        logic signed [11:0] vals [5] = '{12'sd10, 12'sd20, 12'sd30, 12'sd40, 12'sd50};
        do_reset();
        dc_bypass = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cic_in = vals[i];
            for (int j = 0; j < DECIM; j++) drive_cycle(1'b1);
        end
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        void'(exp_q.pop_back());
        vectors++;
        if (level !== 3'd4) begin miscompares++; $display("FAIL ovf_level: got %0d, required 4", level); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        drive_cycle(1'b0);
        vectors++;
        if (out_data !== 16'sd160) begin miscompares++; $display("FAIL head_hold: got %0d, required 160", out_data); end
        clr_ovf = 1'b1;
        drive_cycle(1'b0);
        clr_ovf = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_ovf: got %b, required 0", overflow); end
        // Push into a full FIFO on the same edge as a pop.
        cic_in = 12'sd60;
        for (int j = 0; j < DECIM; j++) drive_cycle(1'b1);
        out_ready = 1'b1;
        drive_cycle(1'b0);
        out_ready = 1'b0;
        vectors++;
        if (level !== 3'd4) begin miscompares++; $display("FAIL pushpop_level: got %0d, required 4", level); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL pushpop_ovf: got %b, required 0", overflow); end
        vectors++;
        if (out_data !== 16'sd320) begin miscompares++; $display("FAIL pushpop_head: got %0d, required 320", out_data); end
        // A drop coinciding with clr_ovf leaves the flag set.
        cic_in = 12'sd70;
        for (int j = 0; j < DECIM; j++) drive_cycle(1'b1);
        clr_ovf = 1'b1;
        drive_cycle(1'b0);
        clr_ovf = 1'b0;
        void'(exp_q.pop_back());
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL drop_beats_clr: got %b, required 1", overflow); end
        clr_ovf = 1'b1;
        drive_cycle(1'b0);
        clr_ovf = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_after_drop: got %b, required 0", overflow); end
        out_ready = 1'b1;
        drain(20);
        vectors++;
        if (level !== 3'd0) begin miscompares++; $display("FAIL drained_level: got %0d, required 0", level); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        dc_bypass = 1'b1; out_ready = 1'b1; cic_in = 12'sd5;
        for (int j = 0; j < DECIM; j++) drive_cycle(1'b1);
        rst = 1'b1;
        en = 1'b0;
        model_reset();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0);
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL inflight_valid cycle %0d: got %b, required 0", i, out_valid); end
        end
        vectors++;
        if (level !== 3'd0) begin miscompares++; $display("FAIL inflight_level: got %0d, required 0", level); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL inflight_ovf: got %b, required 0", overflow); end
    endtask

    task automatic test_neg_full_scale(input logic byp);
        do_reset();
        dc_bypass = byp; out_ready = 1'b1; cic_in = 12'sh800;
        got_q.delete();
        for (int j = 0; j < DECIM; j++) drive_cycle(1'b1);
        drain(10);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== -32768) begin
            miscompares++;
            $display("FAIL neg_full_scale byp=%b: got %0d samples first %0d, required one sample -32768",
                     byp, got_q.size(), (got_q.size() > 0) ? got_q[0] : 0);
        end
    endtask

    initial begin
        test_reset();
        test_latency_bypass();
        test_dc_removal();
        test_overflow_and_full();
        test_reset_inflight();
        test_neg_full_scale(1'b1);
        test_neg_full_scale(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
